ptp_stamp_counter: RTL
======================

PTP_STAMP_COUNTER -- requirements
Module: ptp_stamp_counter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 96: width of the free-running timestamp counter.
REQ-002 Parameter DEFAULT_STEP, default 64'h0000_0008_0000_0000: per-cycle increment after reset (8 ns, zero fraction).
REQ-003 clk  input  1: single clock for all logic.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 enable_inc_int  input  1: level from the counter register block; its rising edge requests a one-shot offset.
REQ-006 enable_inc_frac  input  1: level from the counter register block; its rising edge requests a step load.
REQ-007 inc_value_int  input  64: signed two's-complement offset, applied to counter bits [95:32].
REQ-008 inc_value_frac  input  64: new per-cycle step, with bits [63:32] integer ns and bits [31:0] fraction.
REQ-009 counter_val  output  96: current timestamp, with bits [95:32] integer ns and bits [31:0] fraction.
REQ-010 step_val  output  64: step currently in use.
REQ-011 adj_done  output  1: one-cycle pulse when an offset has been applied.
REQ-012 step_done  output  1: one-cycle pulse when a new step has been loaded.

Function
REQ-013 The block SHALL register enable_inc_int and enable_inc_frac once (d1) and detect a rising edge as (level && !d1).
REQ-014 In every non-reset cycle without a pending offset, counter_val SHALL update to counter_val + {32'b0, step_val}, modulo 2^96.
REQ-015 The FSM SHALL have two states: RUN (normal increment) and ADJ (apply offset).
REQ-016 A detected offset edge in RUN SHALL capture inc_value_int into an offset register and move the FSM to ADJ.
REQ-017 In ADJ, counter_val SHALL update to counter_val + {32'b0, step_val} + {offset, 32'b0}, modulo 2^96, with the offset sign-extended to 96 bits before the shift.
REQ-018 The ADJ cycle SHALL assert adj_done and return the FSM to RUN.
REQ-019 An offset edge that arrives while the FSM is in ADJ SHALL be dropped; one-shot behaviour requires software to toggle enable_inc_int.
REQ-020 A detected step edge SHALL load inc_value_frac into step_val at the next clock edge and assert step_done in that same cycle.
REQ-021 The increment performed in the cycle of the step load SHALL use the old step; the new step applies from the following cycle.
REQ-022 Simultaneous offset and step edges SHALL both be honoured, with the ADJ cycle using the newly loaded step.
REQ-023 A step value of 0 SHALL freeze counter_val; offsets SHALL still apply while frozen.
REQ-024 Counter wrap-around from 2^96-1 SHALL roll over silently to low values, with no flag.
REQ-025 Offset latency SHALL be 2 cycles from the input edge at clk: one cycle for the edge register, one for the ADJ cycle.

Reset
REQ-026 While reset is high, the block SHALL set counter_val=0, step_val=DEFAULT_STEP, offset=0, FSM=RUN, adj_done=0, step_done=0, and both edge registers=0.
REQ-027 Reset asserted during ADJ SHALL abandon the pending offset, with no adj_done pulse.
REQ-028 A level already high on enable_inc_int or enable_inc_frac when reset is released SHALL NOT be treated as an edge.

Structure
REQ-029 The constants DEFAULT_STEP, the FSM state encoding, and the integer/fraction split point (32) SHALL reside in the shared ptp defines package alongside the counter register addresses.
REQ-030 The block SHALL be a single module with no sub-modules; the edge detector stays inline.

Verification
REQ-031 Release reset and run 10 cycles: counter_val SHALL be 96'h0000_0000_0000_0050_0000_0000, and adj_done and step_done SHALL stay 0.
REQ-032 Pulse enable_inc_frac with inc_value_frac=64'h0000_0007_8000_0000: step_done SHALL fire once, and subsequent deltas SHALL be 7.5 ns (0x7_8000_0000).
REQ-033 Hold enable_inc_int high with inc_value_int=-100: the counter SHALL jump by exactly -100 ns plus one step, adj_done SHALL pulse once, and no further offset SHALL occur while the level stays high.
REQ-034 Fire offset and step edges in the same cycle (offset +1000, step 4 ns): the ADJ delta SHALL be +1000 ns + 4 ns.
REQ-035 Force counter_val near 2^96-8 ns with step 8 ns: counter_val SHALL wrap to exactly 0 with no glitch.
REQ-036 Assert reset in the ADJ cycle: counter_val SHALL be 0, adj_done SHALL stay 0, and step_val SHALL equal DEFAULT_STEP.

Source files
------------

// File: rtl/ptp_stamp_counter_pkg.sv
// Shared PTP definitions: counter register map, step defaults, FSM encoding.
package ptp_stamp_counter_pkg;

    // Integer/fraction split of the timestamp and step words
    localparam int FRAC_W = 32;

    // Step used after reset: 8 ns, zero fraction
    localparam logic [63:0] PTP_DEFAULT_STEP = 64'h0000_0008_0000_0000;

    // Counter register block addresses
    localparam logic [7:0] ADDR_CNT_FRAC  = 8'h00;
    localparam logic [7:0] ADDR_CNT_INT_L = 8'h04;
    localparam logic [7:0] ADDR_CNT_INT_H = 8'h08;
    localparam logic [7:0] ADDR_INC_INT_L = 8'h0C;
    localparam logic [7:0] ADDR_INC_INT_H = 8'h10;
    localparam logic [7:0] ADDR_INC_FRAC  = 8'h14;
    localparam logic [7:0] ADDR_INC_CTRL  = 8'h18;

    // Offset FSM: normal increment, or one cycle applying the captured offset
    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_ADJ = 1'b1
    } ptp_state_t;

endpackage

// File: rtl/ptp_stamp_counter.sv
// Free-running PTP timestamp counter with programmable step and one-shot offset.
module ptp_stamp_counter
    import ptp_stamp_counter_pkg::*;
#(
    parameter int          COUNTER_WIDTH = 96,
    parameter logic [63:0] DEFAULT_STEP  = PTP_DEFAULT_STEP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable_inc_int,
    input  logic                     enable_inc_frac,
    input  logic [63:0]              inc_value_int,
    input  logic [63:0]              inc_value_frac,
    output logic [COUNTER_WIDTH-1:0] counter_val,
    output logic [63:0]              step_val,
    output logic                     adj_done,
    output logic                     step_done
);

    ptp_state_t state, state_nxt;

    logic                     int_d1, frac_d1;
    logic                     edge_arm;   // low in the first cycle after reset
    logic                     int_edge, frac_edge;
    logic [63:0]              offset;
    logic                     apply_adj;
    logic [COUNTER_WIDTH-1:0] ofs_ext;
    logic [COUNTER_WIDTH-1:0] ofs_shift;
    logic [COUNTER_WIDTH-1:0] counter_nxt;

    // Rising edges; levels already high at reset release are masked by edge_arm
    assign int_edge  = enable_inc_int  && !int_d1  && edge_arm;
    assign frac_edge = enable_inc_frac && !frac_d1 && edge_arm;

    // Edge-detect history and arming flag
    always_ff @(posedge clk) begin
        if (reset) begin
            int_d1   <= 1'b0;
            frac_d1  <= 1'b0;
            edge_arm <= 1'b0;
        end else begin
            int_d1   <= enable_inc_int;
            frac_d1  <= enable_inc_frac;
            edge_arm <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nxt;
    end

    // FSM next state: ADJ lasts exactly one cycle; edges seen in ADJ are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (int_edge) state_nxt = ST_ADJ;
            ST_ADJ:  state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // FSM output: add the offset during the ADJ cycle
    always_comb begin
        apply_adj = (state == ST_ADJ);
    end

    // Sign-extend the offset to full width, then align it to the integer field
    always_comb begin
        ofs_ext     = COUNTER_WIDTH'(signed'(offset));
        ofs_shift   = ofs_ext << FRAC_W;
        counter_nxt = counter_val + COUNTER_WIDTH'(step_val)
                    + (apply_adj ? ofs_shift : '0);
    end

    // Offset capture, step load, counter update and done pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_val <= '0;
            step_val    <= DEFAULT_STEP;
            offset      <= '0;
            adj_done    <= 1'b0;
            step_done   <= 1'b0;
        end else begin
            // counter_nxt uses the old step, so a new step applies next cycle
            counter_val <= counter_nxt;
            adj_done    <= apply_adj;
            step_done   <= frac_edge;
            if (frac_edge)
                step_val <= inc_value_frac;
            if (state == ST_RUN && int_edge)
                offset <= inc_value_int;
        end
    end

endmodule
